serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 17 +
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic library blocks.
//   state_t        : 2-bit FSM encoding used by the bit-serial subtractor
//   WIDTH_DEFAULT  : default operand/result width
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor cell computing a - b - bin.
// It can be used alone in a serial datapath or chained for a ripple subtractor.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference bit
//   bout out 1  borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow is generated when a=0 and b=1.
    // An incoming borrow is passed on when a and b are equal.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock, using a single registered borrow flip-flop.
//
// Handshake: when the block is IDLE, start=1 on a rising edge accepts the
// operation and captures a and b on that edge. start is ignored in any other
// state and is not queued. After exactly WIDTH more edges, done rises for a
// single cycle. At that point diff, borrow and zero are valid. They hold their
// values until the next accepted start.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request, sampled only in IDLE
//   a, b       in   WIDTH  operands, captured on the accepting edge
//   busy       out  1      high while shifting
//   done       out  1      one-cycle result-valid pulse
//   diff       out  WIDTH  a - b (mod 2^WIDTH)
//   borrow     out  1      final borrow-out (a < b unsigned)
//   zero       out  1      diff == 0
//   fsm_state  out  2      current FSM state (debug observation)
// ---------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic [1:0]       fsm_state
);

    // The counter only reaches WIDTH-1, so clog2(WIDTH) bits are enough.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             bin_q;
    logic             zacc;
    logic             borrow_q;
    logic             zero_q;
    logic             bit_d;
    logic             bit_bout;
    logic             last_bit;

    full_subtractor u_full_subtractor (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)    state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            bin_q    <= 1'b0;
            zacc     <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        cnt   <= '0;
                        bin_q <= 1'b0;
                        zacc  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_q <= {bit_d, diff_q[WIDTH-1:1]};
                    bin_q  <= bit_bout;
                    cnt    <= cnt + CW'(1);
                    zacc   <= zacc | bit_d;
                    // The flags are published on the edge that processes the
                    // final bit. That bit's contribution is folded in here because
                    // the accumulator has not captured it yet.
                    if (last_bit) begin
                        borrow_q <= bit_bout;
                        zero_q   <= ~(zacc | bit_d);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Outputs (decoded from registers only) ----------------
    assign busy      = (state == ST_SHIFT);
    assign done      = (state == ST_DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign fsm_state = state;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 16;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {diff, borrow, zero}
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive a request so that the next rising edge accepts it (E0). Return #1 after E0.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic ez);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    exp_q.push_back({ed, eb, ez});
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done. "already" is the number of edges past E0 that have already been consumed.
  // Check latency and the result, then check that done lasts only one cycle.
  task automatic wait_done(input int already, input string tag);
    int edges;
    logic [W+1:0] e;
    edges = already;
    while (!done && edges < TIMEOUT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = exp_q.pop_front();
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within %0d edges", tag, TIMEOUT);
    end else begin
      check({tag, "_latency"}, 32'(edges), 32'(W));
      check({tag, "_diff"},    32'(diff),   32'(e[W+1:2]));
      check({tag, "_borrow"},  32'(borrow), 32'(e[1]));
      check({tag, "_zero"},    32'(zero),   32'(e[0]));
      check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_after"}, 32'(fsm_state), 32'd0);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    launch(v.a, v.b, v.diff, v.borrow, v.zero);
    wait_done(0, tag);
  endtask

  // ---------------- test ----------------
  vec_t tbl[10];
  vec_t rv;
  int   pulses;

  initial begin
    tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    tbl[8] = '{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'h8001, 16'hFFFF, 1'b1, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_diff",   32'(diff),      32'd0);
    check("rst_borrow", 32'(borrow),    32'd0);
    check("rst_zero",   32'(zero),      32'd1);
    check("rst_state",  32'(fsm_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Apply the table vectors back to back, which uses the minimum issue interval.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // Apply random vectors and take the expected result from a simple arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rv.a      = W'($urandom_range(0, 65535));
      rv.b      = W'($urandom_range(0, 65535));
      rv.diff   = rv.a - rv.b;
      rv.borrow = (rv.a < rv.b);
      rv.zero   = (rv.diff == '0);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    // Drive a start request in the middle of an operation. The DUT must ignore it.
    launch(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 16'h0009;
    b = 16'h0009;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, "ign");
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("ign_no_extra_done", 32'(pulses), 32'd0);
    check("ign_diff_held",     32'(diff),   32'h7FFF);
    check("ign_zero_held",     32'(zero),   32'd0);

    // Assert reset in the middle of an operation, then run a fresh operation.
    launch(16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    check("abort_busy",   32'(busy),      32'd0);
    check("abort_done",   32'(done),      32'd0);
    check("abort_diff",   32'(diff),      32'd0);
    check("abort_borrow", 32'(borrow),    32'd0);
    check("abort_zero",   32'(zero),      32'd1);
    check("abort_state",  32'(fsm_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rv = '{16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0};
    run_op(rv, "post_abort");

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
